// File: rtl/usb_rx_data_check.sv
// USB data-packet receiver: assembles LSB-first bytes, validates the PID, checks the CRC16 residual,
// and delivers payload bytes while withholding the CRC. Optional byte_count output: USB_RX_BYTE_COUNT_EN.
module usb_rx_data_check #(
  parameter int MAX_BYTES = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic       eop,
  output logic [3:0] pid,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       done,
  output logic       crc_ok,
  output logic       err
`ifdef USB_RX_BYTE_COUNT_EN
  ,
  output logic [9:0] byte_count
`endif
);

  localparam int CW = $clog2(MAX_BYTES + 4);
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_BYTES + 2);

  typedef enum logic [1:0] {S_IDLE, S_PID, S_DATA, S_DRAIN} state_t;

  state_t        state_reg, state_next;
  logic [15:0]   lfsr_reg, lfsr_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [CW-1:0] byte_cnt_reg, byte_cnt_next;
  logic [7:0]    hold_new_reg, hold_new_next;
  logic [7:0]    hold_old_reg, hold_old_next;
  logic [3:0]    pid_reg, pid_next;
  logic          pid_err_reg, pid_err_next;
  logic          ovf_err_reg, ovf_err_next;
  logic [7:0]    data_out_reg, data_out_next;
  logic          data_valid_reg, data_valid_next;
  logic          done_reg, done_next;
  logic          crc_ok_reg, crc_ok_next;
  logic          err_reg, err_next;

  logic [7:0]  byte_in;
  logic        fb;
  logic [15:0] lfsr_step;
  logic        pid_good;
  logic        pkt_good;

  assign byte_in   = {bit_in, shift_reg[7:1]};
  assign fb        = lfsr_reg[15] ^ bit_in;
  assign lfsr_step = {lfsr_reg[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  assign pid_good  = (byte_in[7:4] == ~byte_in[3:0]) &&
                     (byte_in inside {8'hC3, 8'h4B, 8'h87, 8'h0F});
  assign pkt_good  = (state_reg == S_DATA) && (lfsr_reg == 16'h800D) && (bit_cnt_reg == 3'd0) &&
                     (byte_cnt_reg >= CW'(2)) && !pid_err_reg && !ovf_err_reg;

`ifdef USB_RX_BYTE_COUNT_EN
  logic [9:0]    byte_count_reg, byte_count_next;
  logic [CW-1:0] pay_cnt;

  always_comb begin
    pay_cnt = (byte_cnt_reg >= CW'(2)) ? byte_cnt_reg - CW'(2) : '0;
    if (pay_cnt > CW'(MAX_BYTES)) pay_cnt = CW'(MAX_BYTES);
  end
`endif

  always_comb begin
    state_next      = state_reg;
    lfsr_next       = lfsr_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    byte_cnt_next   = byte_cnt_reg;
    hold_new_next   = hold_new_reg;
    hold_old_next   = hold_old_reg;
    pid_next        = pid_reg;
    pid_err_next    = pid_err_reg;
    ovf_err_next    = ovf_err_reg;
    data_out_next   = data_out_reg;
    data_valid_next = 1'b0;
    done_next       = 1'b0;
    crc_ok_next     = 1'b0;
    err_next        = 1'b0;
`ifdef USB_RX_BYTE_COUNT_EN
    byte_count_next = byte_count_reg;
`endif
    // Priority: start aborts anything, then eop closes the packet, then a data bit.
    if (start) begin
      state_next    = S_PID;
      lfsr_next     = 16'hFFFF;
      bit_cnt_next  = 3'd0;
      shift_next    = 8'h00;
      byte_cnt_next = '0;
      hold_new_next = 8'h00;
      hold_old_next = 8'h00;
      pid_next      = 4'h0;
      pid_err_next  = 1'b0;
      ovf_err_next  = 1'b0;
`ifdef USB_RX_BYTE_COUNT_EN
      byte_count_next = 10'd0;
`endif
    end else if (eop) begin
      if (state_reg != S_IDLE) begin
        done_next   = 1'b1;
        crc_ok_next = pkt_good;
        err_next    = !pkt_good;
        state_next  = S_IDLE;
`ifdef USB_RX_BYTE_COUNT_EN
        byte_count_next = 10'(pay_cnt);
`endif
      end
    end else if (bit_valid) begin
      case (state_reg)
        S_PID: begin
          shift_next   = byte_in;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (pid_good) begin
              pid_next   = byte_in[3:0];
              state_next = S_DATA;
            end else begin
              pid_err_next = 1'b1;
              state_next   = S_DRAIN;
            end
          end
        end
        S_DATA: begin
          lfsr_next    = lfsr_step;
          shift_next   = byte_in;
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) begin
            if (byte_cnt_reg >= LAST_IDX) begin
              ovf_err_next = 1'b1;
              state_next   = S_DRAIN;
            end else begin
              byte_cnt_next = byte_cnt_reg + CW'(1);
              // Two bytes of lag keep the trailing CRC bytes from ever leaving the pipeline.
              if (byte_cnt_reg >= CW'(2)) begin
                data_valid_next = 1'b1;
                data_out_next   = hold_old_reg;
              end
              hold_old_next = hold_new_reg;
              hold_new_next = byte_in;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      lfsr_reg       <= 16'hFFFF;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      byte_cnt_reg   <= '0;
      hold_new_reg   <= 8'h00;
      hold_old_reg   <= 8'h00;
      pid_reg        <= 4'h0;
      pid_err_reg    <= 1'b0;
      ovf_err_reg    <= 1'b0;
      data_out_reg   <= 8'h00;
      data_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      crc_ok_reg     <= 1'b0;
      err_reg        <= 1'b0;
`ifdef USB_RX_BYTE_COUNT_EN
      byte_count_reg <= 10'd0;
`endif
    end else begin
      state_reg      <= state_next;
      lfsr_reg       <= lfsr_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      byte_cnt_reg   <= byte_cnt_next;
      hold_new_reg   <= hold_new_next;
      hold_old_reg   <= hold_old_next;
      pid_reg        <= pid_next;
      pid_err_reg    <= pid_err_next;
      ovf_err_reg    <= ovf_err_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      done_reg       <= done_next;
      crc_ok_reg     <= crc_ok_next;
      err_reg        <= err_next;
`ifdef USB_RX_BYTE_COUNT_EN
      byte_count_reg <= byte_count_next;
`endif
    end
  end

  assign pid        = pid_reg;
  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign done       = done_reg;
  assign crc_ok     = crc_ok_reg;
  assign err        = err_reg;
`ifdef USB_RX_BYTE_COUNT_EN
  assign byte_count = byte_count_reg;
`endif

endmodule
